// File: rtl/dmem_arbiter.sv
// Two-port arbiter for the shared single-port DMEM: fixed priority to port 0,
// with a starvation counter that forces a port-1 grant after STARVE_LIMIT losses.

module dmem_arbiter_rport #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  own_d,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic                  rvalid_o,
  output logic [DATA_WIDTH-1:0] rdata_o
);
  logic                  own_q;
  logic [DATA_WIDTH-1:0] hold_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      own_q  <= 1'b0;
      hold_q <= '0;
    end else begin
      own_q <= own_d;
      if (own_q) hold_q <= mem_rdata_i;
    end
  end

  // Owner sees the memory output directly; otherwise the last returned word is held.
  assign rvalid_o = own_q;
  assign rdata_o  = own_q ? mem_rdata_i : hold_q;
endmodule

module dmem_arbiter #(
  parameter int ADDR_WIDTH   = 10,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    p0_valid,
  input  logic                    p0_we,
  input  logic [ADDR_WIDTH-1:0]   p0_addr,
  input  logic [DATA_WIDTH-1:0]   p0_wdata,
  input  logic [DATA_WIDTH/8-1:0] p0_wmask,
  output logic                    p0_ready,
  output logic                    p0_rvalid,
  output logic [DATA_WIDTH-1:0]   p0_rdata,
  input  logic                    p1_valid,
  input  logic                    p1_we,
  input  logic [ADDR_WIDTH-1:0]   p1_addr,
  input  logic [DATA_WIDTH-1:0]   p1_wdata,
  input  logic [DATA_WIDTH/8-1:0] p1_wmask,
  output logic                    p1_ready,
  output logic                    p1_rvalid,
  output logic [DATA_WIDTH-1:0]   p1_rdata,
  output logic                    mem_en,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_wmask,
  input  logic [DATA_WIDTH-1:0]   mem_rdata
);
  localparam int MW = DATA_WIDTH / 8;
  localparam logic [7:0] LIM = 8'(STARVE_LIMIT);

  typedef struct packed {
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [MW-1:0]         wmask;
  } req_t;

  req_t [1:0]                  req;
  req_t                        sel;
  logic [1:0]                  valid, grant, rd_owner_d, rvalid;
  logic [1:0][DATA_WIDTH-1:0]  rdata;
  logic [7:0]                  starve_q, starve_d;

  assign valid  = {p1_valid, p0_valid};
  assign req[0] = '{we: p0_we, addr: p0_addr, wdata: p0_wdata, wmask: p0_wmask};
  assign req[1] = '{we: p1_we, addr: p1_addr, wdata: p1_wdata, wmask: p1_wmask};

  always_comb begin
    grant = '0;
    if (!reset) begin
      if (&valid) grant = (starve_q == LIM) ? 2'b10 : 2'b01;
      else        grant = valid;
    end
  end

  // Only a port-0 win against a waiting port 1 advances the count; anything else clears it.
  always_comb begin
    starve_d = '0;
    if (grant[0] && valid[1]) starve_d = (starve_q == LIM) ? starve_q : starve_q + 8'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) starve_q <= '0;
    else       starve_q <= starve_d;
  end

  always_comb begin
    sel = '0;
    if (grant[1])      sel = req[1];
    else if (grant[0]) sel = req[0];
  end

  assign p0_ready  = grant[0];
  assign p1_ready  = grant[1];
  assign mem_en    = |grant;
  assign mem_we    = sel.we;
  assign mem_addr  = sel.addr;
  assign mem_wdata = sel.wdata;
  assign mem_wmask = sel.wmask;

  for (genvar p = 0; p < 2; p++) begin : g_port
    assign rd_owner_d[p] = grant[p] & ~req[p].we;
    dmem_arbiter_rport #(.DATA_WIDTH(DATA_WIDTH)) u_rport (
      .clk        (clk),
      .reset      (reset),
      .own_d      (rd_owner_d[p]),
      .mem_rdata_i(mem_rdata),
      .rvalid_o   (rvalid[p]),
      .rdata_o    (rdata[p])
    );
  end

  assign p0_rvalid = rvalid[0];
  assign p1_rvalid = rvalid[1];
  assign p0_rdata  = rdata[0];
  assign p1_rdata  = rdata[1];
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed and random checks of dmem_arbiter against a behavioural memory model.

module tb_dmem_arbiter;
  localparam int AW = 10, DW = 32, MW = 4, LIM = 4;

  logic clk = 1'b0, reset = 1'b1, mem_clr = 1'b1;
  logic p0_valid = 0, p0_we = 0, p1_valid = 0, p1_we = 0;
  logic [AW-1:0] p0_addr = '0, p1_addr = '0;
  logic [DW-1:0] p0_wdata = '0, p1_wdata = '0;
  logic [MW-1:0] p0_wmask = '0, p1_wmask = '0;
  logic p0_ready, p0_rvalid, p1_ready, p1_rvalid;
  logic [DW-1:0] p0_rdata, p1_rdata, mem_wdata, mem_rdata;
  logic mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [MW-1:0] mem_wmask;
  // second instance with STARVE_LIMIT = 1, sharing the request stimulus
  logic b_p0_ready, b_p0_rvalid, b_p1_ready, b_p1_rvalid, b_mem_en, b_mem_we;
  logic [DW-1:0] b_p0_rdata, b_p1_rdata, b_mem_wdata;
  logic [AW-1:0] b_mem_addr;
  logic [MW-1:0] b_mem_wmask;
  logic [DW-1:0] zero_rd = '0;

  logic [DW-1:0] env_mem [256];
  logic [DW-1:0] ref_mem [256];
  int n_cmp = 0, n_err = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(LIM)) u_dut (
    .clk(clk), .reset(reset),
    .p0_valid(p0_valid), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_wmask(p0_wmask),
    .p0_ready(p0_ready), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
    .p1_valid(p1_valid), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_wmask(p1_wmask),
    .p1_ready(p1_ready), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_rdata(mem_rdata));

  dmem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(1)) u_dut1 (
    .clk(clk), .reset(reset),
    .p0_valid(p0_valid), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_wmask(p0_wmask),
    .p0_ready(b_p0_ready), .p0_rvalid(b_p0_rvalid), .p0_rdata(b_p0_rdata),
    .p1_valid(p1_valid), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_wmask(p1_wmask),
    .p1_ready(b_p1_ready), .p1_rvalid(b_p1_rvalid), .p1_rdata(b_p1_rdata),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_wmask(b_mem_wmask), .mem_rdata(zero_rd));

  // Synchronous single-port memory with byte enables and 1-cycle read latency.
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) env_mem[i] <= '0;
    end else if (mem_en) begin
      if (mem_we) begin
        for (int b = 0; b < MW; b++)
          if (mem_wmask[b]) env_mem[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end else begin
        mem_rdata <= env_mem[mem_addr[9:2]];
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drv0(input logic v, input logic we, input logic [AW-1:0] a,
                      input logic [DW-1:0] d, input logic [MW-1:0] m);
    p0_valid = v; p0_we = we; p0_addr = a; p0_wdata = d; p0_wmask = m;
  endtask

  task automatic drv1(input logic v, input logic we, input logic [AW-1:0] a,
                      input logic [DW-1:0] d, input logic [MW-1:0] m);
    p1_valid = v; p1_we = we; p1_addr = a; p1_wdata = d; p1_wmask = m;
  endtask

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] d,
                                          input logic [MW-1:0] m);
    logic [DW-1:0] r;
    r = old;
    for (int b = 0; b < MW; b++) if (m[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  logic [9:0] seq4, seq1;
  logic       pend [2];
  logic       pwe  [2];
  logic [AW-1:0] pa [2];
  logic [DW-1:0] pd [2];
  logic [MW-1:0] pm [2];
  int         waitc [2];
  logic       exp_rv [2];
  logic [DW-1:0] exp_rd [2];
  logic [1:0] rdy;

  initial begin
    seq4 = 10'b10000_10000;
    seq1 = 10'b10101_01010;
    repeat (2) @(posedge clk);
    #1; mem_clr = 1'b0; reset = 1'b0;

    // reset during an in-flight read
    drv0(1, 0, 10'h010, '0, '0);
    #4;
    chk("rst_pre_p0_ready", p0_ready, 1);
    reset = 1'b1;
    #1;
    chk("rst_p0_ready", p0_ready, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_bus", {mem_we, mem_addr, mem_wdata, mem_wmask}, 0);
    chk("rst_rvalid", {p0_rvalid, p1_rvalid}, 0);
    chk("rst_rdata", {p0_rdata, p1_rdata}, 0);
    cyc();
    chk("rst_hold_p0_ready", p0_ready, 0);
    reset = 1'b0; drv0(0, 0, '0, '0, '0);
    #4;
    chk("rst_dropped_rvalid", p0_rvalid, 0);
    chk("rst_starve", u_dut.starve_q, 0);
    cyc();
    chk("rst_dropped_rvalid2", p0_rvalid, 0);

    // port 0 alone: write then read back
    drv0(1, 1, 10'h020, 32'hDEADBEEF, 4'hF);
    #4;
    chk("p0w_ready", p0_ready, 1);
    chk("p0w_mem", {mem_en, mem_we, mem_addr}, {1'b1, 1'b1, 10'h020});
    cyc();
    drv0(1, 0, 10'h020, '0, '0);
    #4;
    chk("p0r_ready", p0_ready, 1);
    chk("p0r_mem_we", mem_we, 0);
    cyc();
    drv0(0, 0, '0, '0, '0);
    #4;
    chk("p0r_rvalid", p0_rvalid, 1);
    chk("p0r_rdata", p0_rdata, 32'hDEADBEEF);
    chk("p0r_p1_rvalid", p1_rvalid, 0);
    cyc();
    chk("p0r_rvalid_drop", p0_rvalid, 0);
    chk("p0r_rdata_hold", p0_rdata, 32'hDEADBEEF);

    // starvation: both request continuously
    drv0(1, 0, 10'h100, '0, '0);
    drv1(1, 0, 10'h104, '0, '0);
    for (int i = 0; i < 10; i++) begin
      #4;
      chk($sformatf("starve4_g%0d", i), {p1_ready, p0_ready}, {seq4[i], ~seq4[i]});
      chk($sformatf("starve1_g%0d", i), {b_p1_ready, b_p0_ready}, {seq1[i], ~seq1[i]});
      cyc();
    end
    repeat (4) cyc();
    // counter now at the limit; a lone port 0 must still win immediately
    drv1(0, 0, '0, '0, '0);
    #4;
    chk("starve_single_p0", {p1_ready, p0_ready}, 2'b01);
    cyc();
    drv0(0, 0, '0, '0, '0);
    cyc();

    // interleaved reads from both ports
    drv0(1, 1, 10'h000, 32'h11111111, 4'hF); cyc();
    drv0(1, 1, 10'h004, 32'h22222222, 4'hF); cyc();
    drv0(1, 0, 10'h000, '0, '0);
    #4;
    chk("il_p0_ready", p0_ready, 1);
    cyc();
    drv0(0, 0, '0, '0, '0); drv1(1, 0, 10'h004, '0, '0);
    #4;
    chk("il_p1_ready", p1_ready, 1);
    chk("il_n1_rvalid", {p1_rvalid, p0_rvalid}, 2'b01);
    chk("il_n1_p0_rdata", p0_rdata, 32'h11111111);
    cyc();
    drv1(0, 0, '0, '0, '0);
    #4;
    chk("il_n2_rvalid", {p1_rvalid, p0_rvalid}, 2'b10);
    chk("il_n2_p1_rdata", p1_rdata, 32'h22222222);
    chk("il_n2_p0_hold", p0_rdata, 32'h11111111);
    cyc();

    // byte-mask passthrough from port 1
    drv0(1, 1, 10'h008, 32'h55667788, 4'hF); cyc();
    drv0(0, 0, '0, '0, '0); drv1(1, 1, 10'h008, 32'h000000AB, 4'b0001);
    #4;
    chk("bm_p1_ready", p1_ready, 1);
    chk("bm_mem", {mem_we, mem_addr, mem_wmask, mem_wdata}, {1'b1, 10'h008, 4'b0001, 32'h000000AB});
    cyc();
    drv1(0, 0, '0, '0, '0); drv0(1, 0, 10'h008, '0, '0); cyc();
    drv0(0, 0, '0, '0, '0);
    #4;
    chk("bm_readback", {p0_rvalid, p0_rdata}, {1'b1, 32'h556677AB});
    cyc();

    // random stress against the reference memory
    mem_clr = 1'b1;
    for (int i = 0; i < 256; i++) ref_mem[i] = '0;
    cyc();
    mem_clr = 1'b0;
    for (int p = 0; p < 2; p++) begin
      pend[p] = 0; pwe[p] = 0; pa[p] = '0; pd[p] = '0; pm[p] = '0; waitc[p] = 0;
      exp_rv[p] = 0; exp_rd[p] = '0;
    end
    for (int c = 0; c < 10000; c++) begin
      for (int p = 0; p < 2; p++) begin
        if (!pend[p] && $urandom_range(0, 3) != 0) begin
          pend[p] = 1; pwe[p] = $urandom_range(0, 1) == 1;
          pa[p] = AW'({$urandom_range(0, 15), 2'b00});
          pd[p] = $urandom; pm[p] = MW'($urandom); waitc[p] = 0;
        end
      end
      drv0(pend[0], pwe[0], pa[0], pd[0], pm[0]);
      drv1(pend[1], pwe[1], pa[1], pd[1], pm[1]);
      #4;
      chk("st_p0_rvalid", p0_rvalid, exp_rv[0]);
      chk("st_p1_rvalid", p1_rvalid, exp_rv[1]);
      if (exp_rv[0]) chk("st_p0_rdata", p0_rdata, exp_rd[0]);
      if (exp_rv[1]) chk("st_p1_rdata", p1_rdata, exp_rd[1]);
      chk("st_ready_legal", {p1_ready & p0_ready, p0_ready & ~p0_valid, p1_ready & ~p1_valid}, 0);
      rdy = {p1_ready, p0_ready};
      for (int p = 0; p < 2; p++) begin
        exp_rv[p] = 0;
        if (pend[p] && rdy[p]) begin
          if (pwe[p]) ref_mem[pa[p][9:2]] = merge(ref_mem[pa[p][9:2]], pd[p], pm[p]);
          else begin exp_rv[p] = 1; exp_rd[p] = ref_mem[pa[p][9:2]]; end
          pend[p] = 0;
        end else if (pend[p]) begin
          waitc[p]++;
          chk($sformatf("st_wait_p%0d", p), waitc[p] <= LIM + 1, 1);
        end
      end
      cyc();
    end
    drv0(0, 0, '0, '0, '0); drv1(0, 0, '0, '0, '0);
    #4;
    chk("st_end_p0_rvalid", p0_rvalid, exp_rv[0]);
    chk("st_end_p1_rvalid", p1_rvalid, exp_rv[1]);
    if (exp_rv[0]) chk("st_end_p0_rdata", p0_rdata, exp_rd[0]);
    if (exp_rv[1]) chk("st_end_p1_rdata", p1_rdata, exp_rd[1]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
